// File: rtl/axi4_aw_arbiter.sv
// Two-port AXI4 write-address arbiter with a write-order FIFO that steers the
// W channel so data bursts leave in the same order their addresses were granted.
module axi4_aw_arbiter #(
   parameter int AW_WIDTH    = 69,
   parameter int W_WIDTH     = 37,
   parameter int ORDER_DEPTH = 4
) (
   input  logic                axi4_aclk,
   input  logic                axi4_arstn,
   input  logic                s0_awvalid,
   output logic                s0_awready,
   input  logic [AW_WIDTH-1:0] s0_awdata,
   input  logic                s1_awvalid,
   output logic                s1_awready,
   input  logic [AW_WIDTH-1:0] s1_awdata,
   output logic                m_awvalid,
   input  logic                m_awready,
   output logic [AW_WIDTH-1:0] m_awdata,
   input  logic                s0_wvalid,
   output logic                s0_wready,
   input  logic [W_WIDTH-1:0]  s0_wdata,
   input  logic                s0_wlast,
   input  logic                s1_wvalid,
   output logic                s1_wready,
   input  logic [W_WIDTH-1:0]  s1_wdata,
   input  logic                s1_wlast,
   output logic                m_wvalid,
   input  logic                m_wready,
   output logic [W_WIDTH-1:0]  m_wdata,
   output logic                m_wlast
);

   localparam int PW = $clog2(ORDER_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {IDLE, HOLD} state_t;

   state_t                 state;
   logic                   hold_sel;
   logic                   last_grant;
   logic [ORDER_DEPTH-1:0] order_q;
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [CW-1:0]          count;

   logic full, empty;
   logic gnt_en, gnt_sel;
   logic aw_hs, w_sel, w_pop;

   assign full  = (count == CW'(ORDER_DEPTH));
   assign empty = (count == '0);

   // HOLD pins the grant; in IDLE the grant is decided combinationally.
   always_comb begin
      gnt_en  = 1'b0;
      gnt_sel = 1'b0;
      if (state == HOLD) begin
         gnt_en  = 1'b1;
         gnt_sel = hold_sel;
      end else if (!full) begin
         if (s0_awvalid && s1_awvalid) begin
            gnt_en  = 1'b1;
            gnt_sel = ~last_grant;
         end else if (s0_awvalid) begin
            gnt_en  = 1'b1;
            gnt_sel = 1'b0;
         end else if (s1_awvalid) begin
            gnt_en  = 1'b1;
            gnt_sel = 1'b1;
         end
      end
   end

   // AW outputs are masked by reset since IDLE would otherwise grant combinationally.
   assign m_awvalid  = axi4_arstn & gnt_en & (gnt_sel ? s1_awvalid : s0_awvalid);
   assign m_awdata   = gnt_sel ? s1_awdata : s0_awdata;
   assign s0_awready = axi4_arstn & gnt_en & ~gnt_sel & m_awready;
   assign s1_awready = axi4_arstn & gnt_en &  gnt_sel & m_awready;
   assign aw_hs      = m_awvalid & m_awready;

   assign w_sel     = order_q[rd_ptr];
   assign m_wvalid  = ~empty & (w_sel ? s1_wvalid : s0_wvalid);
   assign m_wdata   = w_sel ? s1_wdata : s0_wdata;
   assign m_wlast   = w_sel ? s1_wlast : s0_wlast;
   assign s0_wready = ~empty & ~w_sel & m_wready;
   assign s1_wready = ~empty &  w_sel & m_wready;
   assign w_pop     = m_wvalid & m_wready & m_wlast;

   always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
      if (!axi4_arstn) begin
         state      <= IDLE;
         hold_sel   <= 1'b0;
         last_grant <= 1'b1;
         order_q    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
      end else begin
         case (state)
            IDLE: if (m_awvalid && !m_awready) begin
               state    <= HOLD;
               hold_sel <= gnt_sel;
            end
            HOLD: if (aw_hs) state <= IDLE;
            default: state <= IDLE;
         endcase
         if (aw_hs) begin
            order_q[wr_ptr] <= gnt_sel;
            wr_ptr          <= wr_ptr + PW'(1);
            last_grant      <= gnt_sel;
         end
         if (w_pop) rd_ptr <= rd_ptr + PW'(1);
         // No bypass: a fresh entry is visible to the W mux only from the next cycle.
         if (aw_hs && !w_pop)      count <= count + CW'(1);
         else if (!aw_hs && w_pop) count <= count - CW'(1);
      end
   end

endmodule
